seg_mux_sched: RTL

SEG_MUX_SCHED -- requirements
Module: seg_mux_sched

---
 rtl/seg_pkg.sv | 12 +
 rtl/sevenseg_decoder.sv | 28 ++
 rtl/seg_mux_sched.sv | 54 +++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding and display constants for the digit scheduler
package seg_pkg;
  typedef enum logic [1:0] {DIG0, BLANK0, DIG1, BLANK1} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF = 2'b11;
  function automatic state_t next_state(input state_t s);
    return s == DIG0 ? BLANK0 : s == BLANK0 ? DIG1 : s == DIG1 ? BLANK1 : DIG0;
  endfunction
  function automatic logic is_digit(input state_t s);
    return s == DIG0 || s == DIG1;
  endfunction
endpackage

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: 4-bit hex to active-low 7-segment glyph, seg[0]=a .. seg[6]=g
module sevenseg_decoder (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg_mux_sched.sv
// seg_mux_sched: two-digit multiplexed 7-segment scheduler with blanking dead time
module seg_mux_sched
  import seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       disp_en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       slot_start
);
  localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  generate
    if (DWELL_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_params
      $error("seg_mux_sched: DWELL_CYCLES and BLANK_CYCLES must both be >= 1");
    end
  endgenerate
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_lim;
  logic [3:0] r_digit;
  logic [6:0] w_glyph;
  logic w_expire, w_dig;
  sevenseg_decoder u_dec (.i_hex(r_digit), .o_seg(w_glyph));
  always_comb begin
    w_dig = is_digit(r_state);
    w_lim = w_dig ? CW'(DWELL_CYCLES - 1) : CW'(BLANK_CYCLES - 1);
    w_expire = r_cnt == w_lim;
    // disable wins over an expiring count and parks in BLANK1 so re-enable gets full dead time
    w_next = !disp_en ? BLANK1 : w_expire ? next_state(r_state) : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BLANK1;
      r_cnt <= '0;
      r_digit <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (!disp_en || w_expire) ? '0 : r_cnt + 1'b1;
      if (disp_en && w_expire && w_next == DIG0) r_digit <= s0;
      if (disp_en && w_expire && w_next == DIG1) r_digit <= s1;
    end
  end
  always_comb begin
    an = r_state == DIG0 ? 2'b10 : r_state == DIG1 ? 2'b01 : AN_OFF;
    seg = w_dig ? w_glyph : SEG_BLANK;
    slot_start = w_dig && r_cnt == '0;
  end
endmodule
